// File: rtl/instr_fetch_buffer.sv
// Y86-64 fetch buffer: reads a 10-byte instruction window from a byte-wide
// memory with one-cycle read latency and presents it over valid/ready.
module instr_fetch_buffer #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [63:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        mem_rd,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [79:0] instr_bytes,
  output logic [63:0] instr_pc,
  output logic        imem_error,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned NBYTES = 10;
  localparam int unsigned SW     = 4;
  localparam int unsigned AW     = 65;
  localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [63:0]     base_q, base_d;
  logic            err_q, err_d;
  logic            mem_rd_q, mem_rd_d;
  logic [63:0]     mem_addr_q, mem_addr_d;
  logic            rd_vld_q, rd_vld_d;
  logic            instr_valid_q, instr_valid_d;
  logic [7:0]      byte_q [NBYTES];
  logic [7:0]      byte_d [NBYTES];
  logic            pc_ready_c;
  logic            accept_c;
  logic [AW-1:0]   next_addr_c;

  // Next-state and datapath; slot_q is the slot driven on the memory port this cycle
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    base_d        = base_q;
    err_d         = err_q;
    mem_rd_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    rd_vld_d      = mem_rd_q;
    instr_valid_d = instr_valid_q;
    byte_d        = byte_q;

    pc_ready_c  = !rst && !flush &&
                  ((state_q == IDLE) || ((state_q == HOLD) && instr_ready));
    accept_c    = pc_valid && pc_ready_c;
    next_addr_c = AW'(base_q) + AW'(slot_q) + AW'(1);

    case (state_q)
      LOAD: begin
        // Data in this cycle belongs to the slot issued last cycle
        if ((slot_q != SW'(0)) && rd_vld_q) byte_d[slot_q - SW'(1)] = mem_rdata;
        if (slot_q == SW'(NBYTES)) begin
          state_d       = HOLD;
          instr_valid_d = 1'b1;
        end else begin
          slot_d = slot_q + SW'(1);
          if (slot_q != SW'(NBYTES - 1)) begin
            mem_rd_d   = (next_addr_c < MEM_LIMIT);
            mem_addr_d = next_addr_c[63:0];
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_d       = IDLE;
          instr_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept_c) begin
      state_d       = LOAD;
      base_d        = pc_in;
      slot_d        = '0;
      err_d         = (AW'(pc_in) >= MEM_LIMIT);
      mem_rd_d      = (AW'(pc_in) < MEM_LIMIT);
      mem_addr_d    = pc_in;
      instr_valid_d = 1'b0;
      for (int i = 0; i < NBYTES; i++) byte_d[i] = 8'h00;
    end

    if (flush) begin
      state_d       = IDLE;
      mem_rd_d      = 1'b0;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      base_q        <= '0;
      err_q         <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      rd_vld_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      for (int i = 0; i < NBYTES; i++) byte_q[i] <= 8'h00;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      base_q        <= base_d;
      err_q         <= err_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      rd_vld_q      <= rd_vld_d;
      instr_valid_q <= instr_valid_d;
      for (int i = 0; i < NBYTES; i++) byte_q[i] <= byte_d[i];
    end
  end

  // byte0 lands in the most significant byte
  for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
    assign instr_bytes[79 - 8*g -: 8] = byte_q[g];
  end

  assign pc_ready    = pc_ready_c;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign instr_pc    = base_q;
  assign imem_error  = err_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: a 4096-byte instance and a 16-byte
// instance share stimulus; each scenario checks the instance it targets.
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, pc_valid, instr_ready;
  logic [63:0] pc_in;

  logic        pc_ready_a, mem_rd_a, imem_error_a, instr_valid_a;
  logic [63:0] mem_addr_a, instr_pc_a;
  logic [79:0] instr_bytes_a;
  logic [7:0]  mem_rdata_a;

  logic        pc_ready_b, mem_rd_b, imem_error_b, instr_valid_b;
  logic [63:0] mem_addr_b, instr_pc_b;
  logic [79:0] instr_bytes_b;
  logic [7:0]  mem_rdata_b;

  logic [7:0]  mem [0:4095];
  logic        sel_b;
  int          n_chk, n_pass;

  instr_fetch_buffer #(.MEM_BYTES(4096)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready_a), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a),
    .mem_rdata(mem_rdata_a), .instr_bytes(instr_bytes_a), .instr_pc(instr_pc_a),
    .imem_error(imem_error_a), .instr_valid(instr_valid_a), .instr_ready(instr_ready)
  );

  instr_fetch_buffer #(.MEM_BYTES(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b),
    .mem_rdata(mem_rdata_b), .instr_bytes(instr_bytes_b), .instr_pc(instr_pc_b),
    .imem_error(imem_error_b), .instr_valid(instr_valid_b), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory; 0xEE when no read was issued exposes bogus captures
  always @(posedge clk) begin
    mem_rdata_a <= mem_rd_a ? mem[mem_addr_a[11:0]] : 8'hEE;
    mem_rdata_b <= mem_rd_b ? mem[mem_addr_b[11:0]] : 8'hEE;
  end

  wire        m_pc_ready = sel_b ? pc_ready_b    : pc_ready_a;
  wire        m_mem_rd   = sel_b ? mem_rd_b      : mem_rd_a;
  wire [63:0] m_mem_addr = sel_b ? mem_addr_b    : mem_addr_a;
  wire [79:0] m_bytes    = sel_b ? instr_bytes_b : instr_bytes_a;
  wire [63:0] m_pc       = sel_b ? instr_pc_b    : instr_pc_a;
  wire        m_err      = sel_b ? imem_error_b  : imem_error_a;
  wire        m_valid    = sel_b ? instr_valid_b : instr_valid_a;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept pc in the current cycle T and follow the load through T+12
  task automatic load_and_check(input logic [63:0] pc, input logic [79:0] exp_bytes,
                                input logic exp_err, input int n_rd, input string name);
    logic exp_rd;
    pc_in = pc;
    pc_valid = 1'b1;
    #1;
    n_chk++;
    if (m_pc_ready !== 1'b1) $display("FAIL %s accept: pc_ready=%b expected 1", name, m_pc_ready);
    else n_pass++;
    step();
    pc_valid = 1'b0;
    instr_ready = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp_rd = (c <= 10) && ((c - 1) < n_rd);
      n_chk++;
      if (m_valid !== 1'b0) $display("FAIL %s valid_low T+%0d: got %b expected 0", name, c, m_valid);
      else n_pass++;
      n_chk++;
      if (m_mem_rd !== exp_rd) $display("FAIL %s mem_rd T+%0d: got %b expected %b", name, c, m_mem_rd, exp_rd);
      else n_pass++;
      if (exp_rd) begin
        n_chk++;
        if (m_mem_addr !== pc + 64'(c - 1))
          $display("FAIL %s mem_addr T+%0d: got %h expected %h", name, c, m_mem_addr, pc + 64'(c - 1));
        else n_pass++;
      end
      step();
    end
    n_chk++;
    if (m_valid !== 1'b1) $display("FAIL %s valid T+12: got %b expected 1", name, m_valid);
    else n_pass++;
    n_chk++;
    if (m_bytes !== exp_bytes) $display("FAIL %s bytes: got %h expected %h", name, m_bytes, exp_bytes);
    else n_pass++;
    n_chk++;
    if (m_pc !== pc) $display("FAIL %s instr_pc: got %h expected %h", name, m_pc, pc);
    else n_pass++;
    n_chk++;
    if (m_err !== exp_err) $display("FAIL %s imem_error: got %b expected %b", name, m_err, exp_err);
    else n_pass++;
  endtask

  task automatic release_instr();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    sel_b = 1'b0;
    rst = 1'b1;
    step();
    n_chk++;
    if (m_pc_ready !== 1'b0) $display("FAIL reset pc_ready: got %b expected 0", m_pc_ready);
    else n_pass++;
    step();
    rst = 1'b0;
    #1;
    n_chk++;
    if ({m_mem_rd, m_valid, m_err} !== 3'b000)
      $display("FAIL reset flags: got rd/valid/err=%b%b%b expected 000", m_mem_rd, m_valid, m_err);
    else n_pass++;
    n_chk++;
    if ({m_mem_addr, m_pc, m_bytes} !== 208'd0)
      $display("FAIL reset data: got addr=%h pc=%h bytes=%h expected zeros", m_mem_addr, m_pc, m_bytes);
    else n_pass++;
    n_chk++;
    if (m_pc_ready !== 1'b1) $display("FAIL reset idle pc_ready: got %b expected 1", m_pc_ready);
    else n_pass++;
    // Reset in the middle of a load
    pc_in = 64'h0;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_chk++;
    if ({m_mem_rd, m_valid, m_mem_addr} !== 66'd0)
      $display("FAIL reset_mid_load: got rd=%b valid=%b addr=%h expected 0", m_mem_rd, m_valid, m_mem_addr);
    else n_pass++;
  endtask

  task automatic test_basic_load();
    sel_b = 1'b0;
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
    load_and_check(64'd0, 80'h30F20A00000000000000, 1'b0, 10, "basic");
  endtask

  task automatic test_backpressure();
    sel_b = 1'b0;
    instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if (m_valid !== 1'b1 || m_pc_ready !== 1'b0)
        $display("FAIL backpressure flags c%0d: valid=%b pc_ready=%b expected 1/0", c, m_valid, m_pc_ready);
      else n_pass++;
      n_chk++;
      if (m_bytes !== 80'h30F20A00000000000000 || m_pc !== 64'd0 || m_err !== 1'b0)
        $display("FAIL backpressure hold c%0d: bytes=%h pc=%h err=%b", c, m_bytes, m_pc, m_err);
      else n_pass++;
      step();
    end
    instr_ready = 1'b1;
    #1;
    n_chk++;
    if (m_pc_ready !== 1'b1) $display("FAIL backpressure ready_rise: pc_ready=%b expected 1", m_pc_ready);
    else n_pass++;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel_b = 1'b0;
    for (int i = 10; i < 20; i++) mem[i] = 8'(8'h10 + i - 10);
    load_and_check(64'd0, 80'h30F20A00000000000000, 1'b0, 10, "b2b_first");
    instr_ready = 1'b1;
    load_and_check(64'd10, 80'h10111213141516171819, 1'b0, 10, "b2b_second");
    release_instr();
  endtask

  task automatic test_tail();
    sel_b = 1'b1;
    mem[12] = 8'h70; mem[13] = 8'h11; mem[14] = 8'h22; mem[15] = 8'h33;
    for (int i = 16; i < 22; i++) mem[i] = 8'hAA;
    load_and_check(64'd12, 80'h70112233000000000000, 1'b0, 4, "tail");
    release_instr();
  endtask

  task automatic test_oob();
    sel_b = 1'b1;
    load_and_check(64'd16, 80'h0, 1'b1, 0, "oob16");
    release_instr();
    sel_b = 1'b0;
    load_and_check(64'hFFFF_FFFF_FFFF_FFFC, 80'h0, 1'b1, 0, "oob_top");
    release_instr();
  endtask

  task automatic test_flush();
    sel_b = 1'b0;
    for (int i = 0; i < 10; i++) mem[64 + i] = 8'(8'hA0 + i);
    pc_in = 64'd0;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    pc_valid = 1'b1;
    pc_in = 64'h20;
    #1;
    n_chk++;
    if (m_pc_ready !== 1'b0) $display("FAIL flush pc_ready_T5: got %b expected 0", m_pc_ready);
    else n_pass++;
    step();
    flush = 1'b0;
    pc_valid = 1'b0;
    #1;
    n_chk++;
    if (m_mem_rd !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL flush T6: mem_rd=%b valid=%b expected 0/0", m_mem_rd, m_valid);
    else n_pass++;
    n_chk++;
    if (m_pc_ready !== 1'b1) $display("FAIL flush pc_ready_T6: got %b expected 1", m_pc_ready);
    else n_pass++;
    load_and_check(64'h40, 80'hA0A1A2A3A4A5A6A7A8A9, 1'b0, 10, "flush_reload");
    release_instr();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    sel_b = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    pc_valid = 1'b0;
    instr_ready = 1'b0;
    pc_in = 64'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_basic_load();
    test_backpressure();
    test_back_to_back();
    test_tail();
    test_oob();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
